// File: rtl/cla_seq_adder_pkg.sv
// cla_seq_adder_pkg: shared slice width, FSM encoding and index sizing for the sequential CLA adder.
package cla_seq_adder_pkg;
    localparam int SLICE_W = 16;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    function automatic int idx_w(input int words);
        return $clog2(words);
    endfunction
endpackage

// File: rtl/cla_seq_adder_if.sv
// cla_seq_adder_if: start/done request bus between issuing control logic and the sequential adder.
interface cla_seq_adder_if #(parameter int WORDS = 4);
    localparam int W = cla_seq_adder_pkg::SLICE_W * WORDS;
    logic         start_i;
    logic         sub_i;
    logic         cin_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovfl_o;
    modport master(output start_i, sub_i, cin_i, a_i, b_i, input busy_o, done_o, sum_o, cout_o, ovfl_o);
    modport slave(input start_i, sub_i, cin_i, a_i, b_i, output busy_o, done_o, sum_o, cout_o, ovfl_o);
endinterface

// File: rtl/cla_seq_adder_cla.sv
// cla_16bit: 16-bit two-level carry-lookahead adder (4-bit groups, group lookahead on top).
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] s_o,
    output logic        cout_o
);
    function automatic logic [3:1] la4(input logic [3:0] g, input logic [3:0] p, input logic c);
        return {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c,
                g[1] | p[1] & g[0] | p[1] & p[0] & c,
                g[0] | p[0] & c};
    endfunction
    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
    endfunction
    logic [15:0] g, p;
    logic [3:0]  gg, gp, gc;
    assign g = a_i & b_i;
    assign p = a_i ^ b_i;
    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:1] bc;
        assign gg[k] = grp_g(g[4*k +: 4], p[4*k +: 4]);
        assign gp[k] = &p[4*k +: 4];
        assign bc = la4(g[4*k +: 4], p[4*k +: 4], gc[k]);
        assign s_o[4*k +: 4] = p[4*k +: 4] ^ {bc, gc[k]};
    end
    assign gc     = {la4(gg, gp, cin_i), cin_i};
    assign cout_o = grp_g(gg, gp) | (&gp) & cin_i;
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: W-bit add/sub built by sequencing one cla_16bit over WORDS slices, LSW first.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input logic              clk,
    input logic              rst_n,
    cla_seq_adder_if.slave   bus
);
    localparam int IW = idx_w(WORDS);
    state_t                          state_q;
    logic [WORDS-1:0][SLICE_W-1:0]   a_q, b_q, sum_q;
    logic [IW-1:0]                   idx_q;
    logic                            sub_q, carry_q, busy_q, done_q, cout_q, ovfl_q;
    logic [SLICE_W-1:0]              cla_a, cla_b, cla_s;
    logic                            cla_c, last;
    assign cla_a = a_q[idx_q];
    assign cla_b = b_q[idx_q] ^ {SLICE_W{sub_q}};
    assign last  = idx_q == IW'(WORDS - 1);
    cla_16bit u_cla (
        .a_i   (cla_a),
        .b_i   (cla_b),
        .cin_i (carry_q),
        .s_o   (cla_s),
        .cout_o(cla_c)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        sub_q   <= bus.sub_i;
                        carry_q <= bus.sub_i ? 1'b1 : bus.cin_i;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= cla_s;
                    carry_q      <= cla_c;
                    idx_q        <= idx_q + 1'b1;
                    if (last) begin
                        // the top slice's sum MSB is the result sign, so overflow is known here
                        cout_q  <= cla_c;
                        ovfl_q  <= (a_q[WORDS-1][SLICE_W-1] == (b_q[WORDS-1][SLICE_W-1] ^ sub_q)) &&
                                   (cla_s[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
    assign bus.ovfl_o = ovfl_q;
endmodule
